// File: rtl/bp_response_meter.sv
// Band-pass response meter: measures peak, peak-to-peak and rising Schmitt crossings over a window.
// Optional feature: define BPRM_OVERRANGE_EN to flag full-scale samples via the overrange output.
module bp_response_meter #(
   parameter int DATA_W   = 12,
   parameter int WINDOW_W = 16,
   parameter int HYST     = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [WINDOW_W-1:0] cfg_window,
   input  logic                start,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [DATA_W-1:0]   s_data,
   output logic                busy,
   output logic                done,
   output logic [DATA_W-1:0]   peak_pos,
   output logic [DATA_W-1:0]   peak_neg,
   output logic [DATA_W:0]     pk_pk,
   output logic [WINDOW_W-1:0] crossings,
   output logic                overrange
);

   typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;

   localparam logic signed [DATA_W-1:0] MAX_CODE = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] MIN_CODE = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [DATA_W-1:0] HYST_P   = DATA_W'(HYST);
   localparam logic signed [DATA_W-1:0] HYST_N   = DATA_W'(-HYST);

   state_t state, state_nxt;

   logic [WINDOW_W-1:0]      rem;
   logic signed [DATA_W-1:0] mx, mn, mx_n, mn_n;
   logic [WINDOW_W-1:0]      xcnt, xcnt_n;
   logic                     first, pos, pos_n;
   logic signed [DATA_W-1:0] x;
   logic [DATA_W:0]          pk_n;
   logic                     acc, last, go;

   assign x    = s_data;
   assign acc  = s_valid && (state == MEASURE);
   assign last = acc && (rem == WINDOW_W'(1));
   assign go   = start && (state == IDLE);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = MEASURE;
         MEASURE: if (last)  state_nxt = REPORT;
         REPORT:             state_nxt = IDLE;
         default:            state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_ready = (state != REPORT);
      busy    = (state != IDLE);
      done    = (state == REPORT);
   end

   // ---------------- per-sample accumulator update ----------------
   always_comb begin
      mx_n   = (x > mx) ? x : mx;
      mn_n   = (x < mn) ? x : mn;
      pos_n  = pos;
      xcnt_n = xcnt;
      if (first) begin
         pos_n = ~x[DATA_W-1];
      end else if (!pos && (x > HYST_P)) begin
         pos_n  = 1'b1;
         xcnt_n = (&xcnt) ? xcnt : xcnt + WINDOW_W'(1);
      end else if (pos && (x < HYST_N)) begin
         pos_n = 1'b0;
      end
      pk_n = {mx_n[DATA_W-1], mx_n} - {mn_n[DATA_W-1], mn_n};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem   <= '0;
         mx    <= MIN_CODE;
         mn    <= MAX_CODE;
         xcnt  <= '0;
         first <= 1'b1;
         pos   <= 1'b0;
      end else if (go) begin
         rem   <= (cfg_window == '0) ? WINDOW_W'(1) : cfg_window;
         mx    <= MIN_CODE;
         mn    <= MAX_CODE;
         xcnt  <= '0;
         first <= 1'b1;
         pos   <= 1'b0;
      end else if (acc) begin
         rem   <= rem - WINDOW_W'(1);
         mx    <= mx_n;
         mn    <= mn_n;
         xcnt  <= xcnt_n;
         first <= 1'b0;
         pos   <= pos_n;
      end
   end

   // Results load on the final handshake so they are visible during REPORT with done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak_pos  <= '0;
         peak_neg  <= '0;
         pk_pk     <= '0;
         crossings <= '0;
      end else if (last) begin
         peak_pos  <= mx_n;
         peak_neg  <= mn_n;
         pk_pk     <= pk_n;
         crossings <= xcnt_n;
      end
   end

`ifdef BPRM_OVERRANGE_EN
   logic ovr, ovr_n;

   assign ovr_n = ovr | (x == MAX_CODE) | (x == MIN_CODE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovr       <= 1'b0;
         overrange <= 1'b0;
      end else begin
         if (go)       ovr <= 1'b0;
         else if (acc) ovr <= ovr_n;
         if (last)     overrange <= ovr_n;
      end
   end
`else
   assign overrange = 1'b0;
`endif

endmodule
